// File: rtl/data_mem_arbiter_if.sv
// Requester ports A/B plus the shared data-memory port of data_mem_arbiter.
// slave = arbiter side, master = requesters and memory side.
interface data_mem_arbiter_if;
  logic        a_req;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_we;
  logic [3:0]  a_sign_mask;
  logic        a_ack;
  logic [31:0] a_rdata;

  logic        b_req;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_we;
  logic [3:0]  b_sign_mask;
  logic        b_ack;
  logic [31:0] b_rdata;

  logic        err;

  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [31:0] mem_read_data;
  logic        mem_stall;

  modport slave (
    input  a_req, a_addr, a_wdata, a_we, a_sign_mask,
    input  b_req, b_addr, b_wdata, b_we, b_sign_mask,
    input  mem_read_data, mem_stall,
    output a_ack, a_rdata, b_ack, b_rdata, err,
    output mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite
  );

  modport master (
    output a_req, a_addr, a_wdata, a_we, a_sign_mask,
    output b_req, b_addr, b_wdata, b_we, b_sign_mask,
    output mem_read_data, mem_stall,
    input  a_ack, a_rdata, b_ack, b_rdata, err,
    input  mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between requesters A and B,
// with a latched command, busy/stall sequencing and a stall watchdog.
module data_mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sign_mask;
  } cmd_t;

  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  cmd_t        cmd_q, a_cmd, b_cmd;
  logic        gnt_b_q, last_b_q;
  logic [7:0]  wd_cnt;
  logic        a_ack_q, b_ack_q, err_q;
  logic [31:0] a_rdata_q, b_rdata_q;
  logic        a_elig, b_elig, pick_b, done, abort;

  assign a_cmd = '{bus.a_addr, bus.a_wdata, bus.a_we, bus.a_sign_mask};
  assign b_cmd = '{bus.b_addr, bus.b_wdata, bus.b_we, bus.b_sign_mask};

  // A port whose ack is high this cycle may still be holding req; ignore it.
  assign a_elig = bus.a_req & ~a_ack_q;
  assign b_elig = bus.b_req & ~b_ack_q;
  assign pick_b = b_elig & (~a_elig | ~last_b_q);

  assign done  = (state == WAIT) & ~bus.mem_stall;
  assign abort = (state == WAIT) & bus.mem_stall & (wd_cnt == TO_M1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (a_elig | b_elig) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (done | abort) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes drop combinationally in the completion cycle so the memory never re-samples.
  always_comb begin
    bus.mem_memread  = 1'b0;
    bus.mem_memwrite = 1'b0;
    if (state == ISSUE || (state == WAIT && bus.mem_stall)) begin
      bus.mem_memread  = ~cmd_q.we;
      bus.mem_memwrite = cmd_q.we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      gnt_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
      wd_cnt    <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (a_elig | b_elig) begin
            cmd_q    <= pick_b ? b_cmd : a_cmd;
            gnt_b_q  <= pick_b;
            last_b_q <= pick_b;
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          if (!bus.mem_stall) begin
            if (gnt_b_q) b_ack_q <= 1'b1;
            else         a_ack_q <= 1'b1;
            if (!cmd_q.we) begin
              if (gnt_b_q) b_rdata_q <= bus.mem_read_data;
              else         a_rdata_q <= bus.mem_read_data;
            end
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
            if (abort) begin
              if (gnt_b_q) b_ack_q <= 1'b1;
              else         a_ack_q <= 1'b1;
              err_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.a_ack          = a_ack_q;
  assign bus.b_ack          = b_ack_q;
  assign bus.err            = err_q;
  assign bus.a_rdata        = a_rdata_q;
  assign bus.b_rdata        = b_rdata_q;
  assign bus.mem_addr       = cmd_q.addr;
  assign bus.mem_write_data = cmd_q.wdata;
  assign bus.mem_sign_mask  = cmd_q.sign_mask;
endmodule
